// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline-to-hazard-unit signal bundle
// master: pipeline datapath side; slave: hazard controller side.
interface hazard_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D;
  logic [4:0]       Rs2D;
  logic [4:0]       Rs1E;
  logic [4:0]       Rs2E;
  logic [4:0]       RdE;
  logic [1:0]       ResultSrcE;
  logic             PCSrcE;
  logic [4:0]       RdM;
  logic             RegWriteM;
  logic             MemReqM;
  logic             MemAckM;
  logic [4:0]       RdW;
  logic             RegWriteW;

  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             StallE;
  logic             FlushE;
  logic             StallM;
  logic             FlushW;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemReqM, MemAckM, RdW, RegWriteW,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, StallE, FlushE,
           StallM, FlushW, mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
           RdM, RegWriteM, MemReqM, MemAckM, RdW, RegWriteW,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, StallE, FlushE,
           StallM, FlushW, mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - 5-stage pipeline hazard controller
// Forwarding, load-use stall, branch flush, data-memory wait with timeout, perf counters.
module hazard_unit #(
  parameter int CNT_W       = 16,
  parameter int TO_W        = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic         clk,
  input  logic         rst,
  hazard_unit_if.slave hz
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] TIMEOUT_V = TO_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [TO_W-1:0]  wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic [1:0] fwd_a, fwd_b;
  logic       load_use, mem_wait;
  logic       stall_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_w;

  // Memory stage holds the younger result, so it wins over Writeback.
  always_comb begin
    fwd_a = 2'b00;
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs1E))
      fwd_a = 2'b10;
    else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs1E))
      fwd_a = 2'b01;
  end

  always_comb begin
    fwd_b = 2'b00;
    if (hz.RegWriteM && (hz.RdM != 5'd0) && (hz.RdM == hz.Rs2E))
      fwd_b = 2'b10;
    else if (hz.RegWriteW && (hz.RdW != 5'd0) && (hz.RdW == hz.Rs2E))
      fwd_b = 2'b01;
  end

  assign load_use = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                    ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));

  assign mem_wait = hz.MemReqM && !hz.MemAckM;

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    stall_e   = 1'b0;
    flush_e   = 1'b0;
    stall_m   = 1'b0;
    flush_w   = 1'b0;

    case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          state_d = S_WAIT;
          wait_d  = TO_W'(1);
        end
      end
      S_WAIT: begin
        if (hz.MemAckM) begin
          state_d = S_RUN;
          wait_d  = '0;
        end else if (wait_q == TIMEOUT_V) begin
          state_d   = S_ERR;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_RUN;
        wait_d  = '0;
      end
    endcase

    // Frozen Execute means branch and load-use decisions wait for release.
    if ((state_q == S_ERR) || mem_wait) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.PCSrcE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_f && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_d && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.ForwardAE    = fwd_a;
  assign hz.ForwardBE    = fwd_b;
  assign hz.StallF       = stall_f;
  assign hz.StallD       = stall_d;
  assign hz.FlushD       = flush_d;
  assign hz.StallE       = stall_e;
  assign hz.FlushE       = flush_e;
  assign hz.StallM       = stall_m;
  assign hz.FlushW       = flush_w;
  assign hz.mem_timeout  = timeout_q;
  assign hz.stall_cycles = stall_cnt_q;
  assign hz.flush_events = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - scoreboard bench for hazard_unit
// Driver queues hand-computed expectations; negedge monitor pops and compares.
module tb_hazard_unit;
  localparam int CNT_W = 3;

  // {StallF, StallD, FlushD, StallE, FlushE, StallM, FlushW}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_LW   = 7'b1100100;
  localparam logic [6:0] C_BR   = 7'b0010100;
  localparam logic [6:0] C_MW   = 7'b1101011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_unit_if #(.CNT_W(CNT_W)) hif();

  hazard_unit #(
    .CNT_W      (CNT_W),
    .TO_W       (8),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hif.slave)
  );

  typedef struct {
    string            name;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [6:0]       ctl;
    logic             to;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [6:0] mon_ctl;
  int applied = 0;
  int miscompares = 0;

  task automatic idle_inputs();
    hif.Rs1D = 5'd0; hif.Rs2D = 5'd0; hif.Rs1E = 5'd0; hif.Rs2E = 5'd0;
    hif.RdE = 5'd0; hif.ResultSrcE = 2'b00; hif.PCSrcE = 1'b0;
    hif.RdM = 5'd0; hif.RegWriteM = 1'b0; hif.MemReqM = 1'b0; hif.MemAckM = 1'b0;
    hif.RdW = 5'd0; hif.RegWriteW = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
  endtask

  task automatic push(input string name, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [6:0] ctl, input logic to, input int sc, input int fc);
    exp_t e;
    e.name = name; e.fa = fa; e.fb = fb; e.ctl = ctl; e.to = to;
    e.sc = CNT_W'(sc); e.fc = CNT_W'(fc);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e   = sb.pop_front();
      mon_ctl = {hif.StallF, hif.StallD, hif.FlushD, hif.StallE,
                 hif.FlushE, hif.StallM, hif.FlushW};
      applied++;
      if (hif.ForwardAE !== mon_e.fa || hif.ForwardBE !== mon_e.fb ||
          mon_ctl !== mon_e.ctl || hif.mem_timeout !== mon_e.to ||
          hif.stall_cycles !== mon_e.sc || hif.flush_events !== mon_e.fc) begin
        miscompares++;
        $display("FAIL %s: got fa=%b fb=%b ctl=%b to=%b stall=%0d flush=%0d, want fa=%b fb=%b ctl=%b to=%b stall=%0d flush=%0d",
                 mon_e.name, hif.ForwardAE, hif.ForwardBE, mon_ctl, hif.mem_timeout,
                 hif.stall_cycles, hif.flush_events, mon_e.fa, mon_e.fb, mon_e.ctl,
                 mon_e.to, mon_e.sc, mon_e.fc);
      end
    end
  end

  initial begin
    rst = 1'b0;
    idle_inputs();

    step(); rst = 1'b0; push("reset", 2'b00, 2'b00, C_NONE, 1'b0, 0, 0);

    step(); hif.Rs1E = 5; hif.RdM = 5; hif.RegWriteM = 1; hif.RdW = 5; hif.RegWriteW = 1;
    push("fwdA_mem", 2'b10, 2'b00, C_NONE, 1'b0, 0, 0);
    step(); hif.Rs1E = 5; hif.RdM = 5; hif.RegWriteM = 0; hif.RdW = 5; hif.RegWriteW = 1;
    push("fwdA_wb", 2'b01, 2'b00, C_NONE, 1'b0, 0, 0);
    step(); hif.Rs1E = 5; hif.RdM = 0; hif.RegWriteM = 1; hif.RdW = 0; hif.RegWriteW = 1;
    push("fwdA_x0", 2'b00, 2'b00, C_NONE, 1'b0, 0, 0);
    step(); hif.Rs2E = 5; hif.RdM = 5; hif.RegWriteM = 1; hif.RdW = 5; hif.RegWriteW = 1;
    push("fwdB_mem", 2'b00, 2'b10, C_NONE, 1'b0, 0, 0);
    step(); hif.Rs2E = 5; hif.RdM = 5; hif.RegWriteM = 0; hif.RdW = 5; hif.RegWriteW = 1;
    push("fwdB_wb", 2'b00, 2'b01, C_NONE, 1'b0, 0, 0);
    step(); hif.Rs2E = 5; hif.RdM = 0; hif.RegWriteM = 1; hif.RdW = 0; hif.RegWriteW = 1;
    push("fwdB_x0", 2'b00, 2'b00, C_NONE, 1'b0, 0, 0);
    step(); hif.Rs1E = 3; hif.RdM = 3; hif.RegWriteM = 1; hif.Rs2E = 4; hif.RdW = 4; hif.RegWriteW = 1;
    push("fwd_both", 2'b10, 2'b01, C_NONE, 1'b0, 0, 0);

    step(); hif.ResultSrcE = 2'b01; hif.RdE = 7; hif.Rs2D = 7;
    push("load_use_rs2", 2'b00, 2'b00, C_LW, 1'b0, 0, 0);
    step(); push("after_load_use", 2'b00, 2'b00, C_NONE, 1'b0, 1, 0);
    step(); hif.ResultSrcE = 2'b01; hif.RdE = 0;
    push("load_use_x0", 2'b00, 2'b00, C_NONE, 1'b0, 1, 0);
    step(); hif.ResultSrcE = 2'b01; hif.RdE = 9; hif.Rs1D = 9;
    push("load_use_rs1", 2'b00, 2'b00, C_LW, 1'b0, 1, 0);
    step(); hif.ResultSrcE = 2'b00; hif.RdE = 9; hif.Rs1D = 9;
    push("not_a_load", 2'b00, 2'b00, C_NONE, 1'b0, 2, 0);

    step(); hif.PCSrcE = 1; hif.ResultSrcE = 2'b01; hif.RdE = 7; hif.Rs2D = 7;
    push("branch_over_lu", 2'b00, 2'b00, C_BR, 1'b0, 2, 0);
    step(); push("after_branch", 2'b00, 2'b00, C_NONE, 1'b0, 2, 1);

    for (int i = 0; i < 3; i++) begin
      step(); hif.MemReqM = 1; hif.PCSrcE = (i == 1);
      push("mem_wait", 2'b00, 2'b00, C_MW, 1'b0, 2 + i, 1);
    end
    step(); hif.MemReqM = 1; hif.MemAckM = 1;
    push("mem_ack", 2'b00, 2'b00, C_NONE, 1'b0, 5, 1);
    step(); hif.MemReqM = 1; hif.MemAckM = 1;
    push("mem_same_cycle_ack", 2'b00, 2'b00, C_NONE, 1'b0, 5, 1);
    for (int i = 0; i < 5; i++) begin
      step(); push("post_ack_idle", 2'b00, 2'b00, C_NONE, 1'b0, 5, 1);
    end

    step(); rst = 1'b0; push("reset_again", 2'b00, 2'b00, C_NONE, 1'b0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(); hif.MemReqM = 1;
      push("timeout_wait", 2'b00, 2'b00, C_MW, 1'b0, i, 0);
    end
    step(); hif.PCSrcE = 1; push("err_hold", 2'b00, 2'b00, C_MW, 1'b1, 5, 0);
    step(); push("err_hold", 2'b00, 2'b00, C_MW, 1'b1, 6, 0);
    step(); push("err_hold", 2'b00, 2'b00, C_MW, 1'b1, 7, 0);
    step(); push("err_stall_sat", 2'b00, 2'b00, C_MW, 1'b1, 7, 0);
    step(); rst = 1'b0; push("async_reset_mid", 2'b00, 2'b00, C_NONE, 1'b0, 0, 0);
    step(); push("after_async_reset", 2'b00, 2'b00, C_NONE, 1'b0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      step(); hif.ResultSrcE = 2'b01; hif.RdE = 7; hif.Rs2D = 7;
      push("lu_saturate", 2'b00, 2'b00, C_LW, 1'b0, (i > 7) ? 7 : i, 0);
    end
    step(); push("lu_saturate_end", 2'b00, 2'b00, C_NONE, 1'b0, 7, 0);

    for (int g = 0; g < 10 && sb.size() != 0; g++) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline hazard controller for the 5-stage core. Drives the flush input of the decode/execute pipeline register and the stall/flush controls of the other stage registers.
- Consumes the register indices that the decode/execute register forwards to Execute (Rs1E, Rs2E, RdE), plus Memory/Writeback writeback info.
- Produces ALU operand forwarding selects, load-use stalls, branch/jump flushes, and multi-cycle data-memory wait stalls with a timeout.
- Maintains saturating stall and flush performance counters.

Parameters:
- CNT_W, 16, width of the performance counters
- TO_W, 8, width of the memory-wait counter
- MEM_TIMEOUT, 200, maximum memory-wait cycles before a timeout error (1 to 2^TO_W-1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Rs1D  in  5  rs1 index in Decode
- Rs2D  in  5  rs2 index in Decode
- Rs1E  in  5  rs1 index in Execute
- Rs2E  in  5  rs2 index in Execute
- RdE  in  5  destination register in Execute
- ResultSrcE  in  2  result source in Execute; 2'b01 = load
- PCSrcE  in  1  taken branch or jump resolved in Execute
- RdM  in  5  destination register in Memory
- RegWriteM  in  1  Memory stage writes a register
- MemReqM  in  1  load or store active in Memory
- MemAckM  in  1  data memory completes the access this cycle
- RdW  in  5  destination register in Writeback
- RegWriteW  in  1  Writeback stage writes a register
- ForwardAE  out  2  operand A select: 00 = register file, 01 = W result, 10 = M ALU result
- ForwardBE  out  2  operand B select, same encoding
- StallF  out  1  hold the PC
- StallD  out  1  hold the fetch/decode register
- FlushD  out  1  clear the fetch/decode register
- StallE  out  1  hold the decode/execute register
- FlushE  out  1  clear the decode/execute register (its flush input)
- StallM  out  1  hold the execute/memory register
- FlushW  out  1  insert a bubble into the memory/writeback register
- mem_timeout  out  1  sticky timeout error flag
- stall_cycles  out  CNT_W  count of cycles with StallF=1
- flush_events  out  CNT_W  count of cycles with FlushD=1

Behaviour:
- Forwarding (combinational): ForwardAE=10 if RegWriteM and RdM!=0 and RdM==Rs1E. Otherwise 01 if RegWriteW and RdW!=0 and RdW==Rs1E. Otherwise 00.
  - Memory stage wins over Writeback. ForwardBE is the same using Rs2E.
- Load-use: lw = (ResultSrcE==01) and RdE!=0 and (RdE==Rs1D or RdE==Rs2D).
- Memory wait: mw = MemReqM and !MemAckM, evaluated in states RUN and WAIT.
- FSM states: RUN, WAIT, ERR.
  - RUN: mw -> WAIT with wait_cnt=1; otherwise stay in RUN.
  - WAIT: MemAckM -> RUN with wait_cnt=0. Else if wait_cnt==MEM_TIMEOUT -> ERR and mem_timeout<=1. Else wait_cnt++.
  - ERR: terminal until reset.
- Output priority (combinational from state and inputs):
  - ERR: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0.
  - mw: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0. Load-use and PCSrcE are ignored, because Execute is frozen and they are re-evaluated on release.
  - PCSrcE: FlushD=1, FlushE=1, StallF=StallD=0. Load-use is suppressed because the Decode instruction is discarded.
  - lw: StallF=StallD=1, FlushE=1.
  - Otherwise all stall and flush outputs are 0.
- A memory access with MemAckM=1 in the same cycle as MemReqM causes no stall and no state change.
- Counters: stall_cycles += 1 when StallF=1; flush_events += 1 when FlushD=1. Both saturate at 2^CNT_W-1 and never wrap.
- Reset (rst=0, asynchronous): state=RUN, wait_cnt=0, mem_timeout=0, both counters=0.
  - Combinational outputs follow their inputs with state=RUN.
  - Reset asserted while in WAIT or ERR aborts immediately to RUN.
- Register latency: state and counters update at the rising clk edge after the qualifying cycle.

Test Plan:
- Forwarding: Rs1E=5, RdM=5, RegWriteM=1, RdW=5, RegWriteW=1 -> ForwardAE=10. Drop RegWriteM -> 01. RdM=RdW=0 -> 00. Repeat on Rs2E/ForwardBE.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle, stall_cycles 0->1. Same with RdE=0 -> no stall.
- Branch vs load-use: PCSrcE=1 together with the load-use condition -> FlushD=FlushE=1, StallF=0. flush_events increments by 1; stall_cycles unchanged.
- Memory wait: MemReqM=1, MemAckM=0 for 3 cycles then ack -> StallF/D/E/M=FlushW=1 for exactly 3 cycles, state RUN after ack, stall_cycles=3. PCSrcE=1 during the wait has no effect.
- Timeout: MEM_TIMEOUT=4, MemReqM=1, ack never asserted -> mem_timeout=1 after the 5th wait cycle, all stalls held. Asserting rst=0 asynchronously clears everything mid-cycle.
- Saturation: CNT_W=3, hold the load-use condition for 10 cycles -> stall_cycles sticks at 7.
